// File: rtl/busca_instrucao.sv
// busca_instrucao: PC-driven instruction fetch that absorbs the 1-cycle memory latency
// and delivers {pc, instr} to decode through a 2-entry valid/ready buffer.
module busca_instrucao #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Fetch_En,
   input  logic              Redirect_En,
   input  logic [ADDR_W-1:0] Redirect_Addr,
   output logic [ADDR_W-1:0] Mem_Address,
   input  logic [DATA_W-1:0] Mem_Q,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Instr,
   output logic [ADDR_W-1:0] Out_PC
);
   logic [ADDR_W-1:0] pc, pend_pc, head_pc, tail_pc;
   logic [DATA_W-1:0] head_instr, tail_instr;
   logic [1:0] count;
   logic pend, pop, push, issue;

   assign Mem_Address = pc;
   assign Out_Valid = count != 2'd0;
   assign Out_Instr = Out_Valid ? head_instr : '0;
   assign Out_PC = Out_Valid ? head_pc : '0;
   assign pop = Out_Valid & Out_Ready;
   assign push = pend & ~Redirect_En;
   // Credit check: a read is only issued if its return is guaranteed a slot.
   assign issue = Fetch_En & ~Redirect_En & (({1'b0, count} + {2'b0, pend} - {2'b0, pop}) < 3'd2);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc <= '0;
         pend <= 1'b0;
         count <= '0;
      end else if (Redirect_En) begin
         pc <= Redirect_Addr;
         pend <= 1'b0;
         count <= '0;
      end else begin
         pend <= issue;
         if (issue) begin
            pend_pc <= pc;
            pc <= pc + ADDR_W'(1);
         end
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            head_pc <= tail_pc;
            head_instr <= tail_instr;
         end
         // Returning read lands in the first free slot after this cycle's pop.
         if (push && (count - {1'b0, pop}) == 2'd0) begin
            head_pc <= pend_pc;
            head_instr <= Mem_Q;
         end else if (push) begin
            tail_pc <= pend_pc;
            tail_instr <= Mem_Q;
         end
      end
   end
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed and random stimulus against a transaction-level model;
// expected instructions are queued on issue and popped by a monitor on every transfer.
module tb_busca_instrucao;
   localparam int AW = 4;
   localparam int DW = 16;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fetch_en = 1'b0;
   logic redirect_en = 1'b0;
   logic out_ready = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic [AW-1:0] mem_address, out_pc;
   logic [DW-1:0] mem_q, out_instr;
   logic out_valid;
   logic [DW-1:0] mem [16];

   entry_t sb[$];
   entry_t mon_e;
   int checks = 0;
   int errors = 0;
   bit go = 1'b0;
   logic [AW-1:0] m_pc = '0;
   logic [AW-1:0] m_pend_pc = '0;
   bit m_pend = 1'b0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_q <= mem[mem_address];

   busca_instrucao #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .Clock(clk),
      .Reset(rst),
      .Fetch_En(fetch_en),
      .Redirect_En(redirect_en),
      .Redirect_Addr(redirect_addr),
      .Mem_Address(mem_address),
      .Mem_Q(mem_q),
      .Out_Valid(out_valid),
      .Out_Ready(out_ready),
      .Out_Instr(out_instr),
      .Out_PC(out_pc)
   );

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (go) begin
         chk("mem_address", int'(mem_address), int'(m_pc));
         chk("out_valid", int'(out_valid), int'(m_cnt != 0));
         assert (dut.count <= 2'd2) else begin
            errors++;
            $display("FAIL count_overflow got %0d expected <=2", dut.count);
         end
         if (!out_valid) begin
            chk("idle_pc", int'(out_pc), 0);
            chk("idle_instr", int'(out_instr), 0);
         end else if (out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_transfer got pc %0h expected no transfer", out_pc);
            end else begin
               mon_e = sb.pop_front();
               chk("out_pc", int'(out_pc), int'(mon_e.pc));
               chk("out_instr", int'(out_instr), int'(mon_e.instr));
            end
         end
      end
   end

   task automatic model(bit r, bit fe, bit re, logic [AW-1:0] ra, bit rdy);
      bit pop, iss;
      pop = (m_cnt != 0) && rdy;
      if (r) begin
         m_pc = '0;
         m_pend = 0;
         m_cnt = 0;
         sb.delete();
      end else if (re) begin
         m_pc = ra;
         m_pend = 0;
         m_cnt = 0;
         sb.delete();
      end else begin
         iss = fe && (m_cnt + int'(m_pend) - int'(pop) < 2);
         if (m_pend) begin
            sb.push_back(entry_t'{pc: m_pend_pc, instr: mem[m_pend_pc]});
            m_cnt++;
         end
         if (pop) m_cnt--;
         m_pend = iss;
         if (iss) begin
            m_pend_pc = m_pc;
            m_pc = m_pc + 1'b1;
         end
      end
   endtask

   task automatic step(bit r, bit fe, bit re, logic [AW-1:0] ra, bit rdy);
      rst = r;
      fetch_en = fe;
      redirect_en = re;
      redirect_addr = ra;
      out_ready = rdy;
      @(posedge clk);
      model(r, fe, re, ra, rdy);
      go = 1'b1;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         mem[i] = (i == 1 || i == 6) ? 16'h60A0 : (i <= 5 ? 16'h40A0 : 16'h0000);
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (20) step(0, 1, 0, 0, 1);
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (4) step(0, 1, 0, 0, 1);
      repeat (5) step(0, 1, 0, 0, 0);
      repeat (8) step(0, 1, 0, 0, 1);
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (3) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 4'd6, 1);
      repeat (8) step(0, 1, 0, 0, 1);
      repeat (6) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      repeat (8) step(0, 1, 0, 0, 1);
      repeat (6) step(0, 0, 0, 0, 1);
      repeat (6) step(0, 1, 0, 0, 1);
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (5) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 4'd0, 1);
      repeat (6) step(0, 1, 0, 0, 1);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
      repeat (2) step(1, 1, 0, 0, 1);
      for (int n = 0; n < 3000; n++)
         step($urandom_range(99) == 0, $urandom_range(9) < 8, $urandom_range(19) == 0,
              AW'($urandom), $urandom_range(9) < 7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage directly upstream of `memoria_instrucoes`. It holds the program counter, drives the memory address, and absorbs the memory's 1-cycle synchronous read latency. Fetched instructions are delivered, tagged with their PC, to the decode stage over a valid/ready handshake. A redirect input (branch/jump) flushes the stage. A 2-entry output buffer keeps throughput at one instruction per cycle under backpressure without losing in-flight reads.

## Interface

- `ADDR_W`, 4, PC / memory address width (16 words)
- `DATA_W`, 16, instruction width
- `Clock`  in  1  single clock, all state updates on rising edge
- `Reset`  in  1  synchronous, active-high
- `Fetch_En`  in  1  permits new memory requests
- `Redirect_En`  in  1  flush and load PC (one-cycle pulse or held)
- `Redirect_Addr`  in  ADDR_W  new PC when `Redirect_En`=1
- `Mem_Address`  out  ADDR_W  to `memoria_instrucoes` Address
- `Mem_Q`  in  DATA_W  from `memoria_instrucoes` Q
- `Out_Valid`  out  1  head of buffer holds an instruction
- `Out_Ready`  in  1  decode accepts head this cycle
- `Out_Instr`  out  DATA_W  instruction at head
- `Out_PC`  out  ADDR_W  address it was fetched from

## Operation

- State:
  - `pc` (next address to request)
  - `pend` (a read was issued last cycle, so `Mem_Q` is valid this cycle)
  - `pend_pc`
  - 2-entry FIFO of {pc, instr} with `count` 0..2
- `Mem_Address` = `pc` at all times, combinational from the register.
- pop = `Out_Valid & Out_Ready`.
- issue = `Fetch_En & !Redirect_En & (count + pend - pop < 2)`.
  - Credit rule: an issued read always has a buffer slot when it returns.
- On issue, at the edge:
  - `pend`<=1, `pend_pc`<=`pc`
  - `pc`<=`pc`+1, mod 2^ADDR_W (15 wraps to 0)
- Without issue: `pend`<=0 and `pc` holds.
- Push: when `pend`=1 and `Redirect_En`=0, {`pend_pc`, `Mem_Q`} is written to the FIFO tail.
  - Push and pop may occur in the same cycle.
  - `count` never exceeds 2; reaching 3 is a design error, and the bench asserts against it.
- Redirect has priority over everything:
  - at the edge, `count`<=0, `pend`<=0, `pc`<=`Redirect_Addr`
  - the returning read is discarded
  - no issue occurs in the redirect cycle
  - a simultaneous pop is still a legal transfer to decode
- `Out_Valid` = (`count`!=0).
- `Out_Instr`/`Out_PC` show the FIFO head. Both are 0 when `Out_Valid`=0.
- Instruction contents are not interpreted. Opcode 0 (NOP) is passed through like any other instruction.

## Timing

- Reset: while `Reset`=1, at every edge:
  - `pc`<=0, `pend`<=0, `count`<=0
  - `Out_Valid`=0, `Out_Instr`=0, `Out_PC`=0, `Mem_Address`=0
  - No issue during reset cycles.
  - Reset mid-operation discards all buffered and in-flight data.
- Latency, issue to visible:
  - issue in cycle N
  - memory registers at edge N
  - push at edge N+1
  - `Out_Valid` in cycle N+2
- First instruction after reset: `Reset` is sampled low at edge R. Issue of PC 0 occurs in cycle R+1, and `Out_Valid`=1 with PC 0 in cycle R+3.
- Steady state with `Out_Ready`=1: one instruction per cycle, consecutive PCs, no bubbles.
- Backpressure:
  - Head and its outputs stay stable while `Out_Valid & !Out_Ready`.
  - With the buffer full, issue stops and `Mem_Address` holds.
  - No instruction is dropped or duplicated.
- Redirect asserted in cycle N:
  - `Out_Valid`=0 in cycle N+1
  - issue of `Redirect_Addr` in cycle N+1 (if `Fetch_En`)
  - `Out_Valid` in cycle N+3
- `Fetch_En` low: buffered entries and a pending read still drain. When `Fetch_En` returns, fetching resumes at the held `pc`.
- Combinational path `Out_Ready` -> issue exists. `Mem_Address` does not depend on it.

## Test plan

Memory is loaded by its reset as: 0:`16'h40A0`, 1:`16'h60A0`, 2–5:`16'h40A0`, 6:`16'h60A0`, 7–15:`16'h0000`. Both blocks are reset together.

- Reset release, `Fetch_En`=1, `Out_Ready`=1 -> `Out_Valid` rises 3 cycles after the release edge. Out sequence (PC/instr): 0/40A0, 1/60A0, 2–5/40A0, 6/60A0, 7–15/0000, then 0/40A0 (wrap). One per cycle, no gaps.
- Streaming, drop `Out_Ready` for 5 cycles while head is PC 2 -> head holds 2/40A0, `count` reaches 2, `Mem_Address` freezes. After release: 2, 3, 4, 5 in consecutive cycles, with no loss and no repeats.
- `Redirect_En` pulse with `Redirect_Addr`=6 while head is PC 1 -> `Out_Valid`=0 the next cycle. Next valid output is 6/60A0, 3 cycles after the pulse, followed by 7/0000. PCs 2–3 never appear.
- `Reset` for 1 cycle while the buffer is full and `Out_Ready`=0 -> `Out_Valid`=0 and `Mem_Address`=0 the next cycle. The stream restarts at 0/40A0 per the latency rule.
- `Fetch_En` low for 6 cycles with `Out_Ready`=1, starting after PC 4 is issued -> PCs up to 4 drain, then `Out_Valid`=0. Re-enable -> 5/40A0 appears 2 cycles after the re-enable cycle.
- `Redirect_En` (addr 0) in the same cycle as a pop of PC 3 -> PC 3 is transferred. Everything else is flushed, and the next output is 0/40A0.
